zigzag_rle_encoder: RTL and testbench
=====================================

// Module: zigzag_rle_encoder
// PURPOSE
//  Consumes quantized 8x8 coefficients already in zigzag order, 64 beats per block, from the zigzag RAM read side.
//  Emits JPEG entropy-coding symbols (run, size, amplitude) for the Huffman stage.
//  DC is coded as a difference against a running predictor. AC is run-length coded with ZRL (16 zeros) and EOB.
// PARAMETERS
//  DATA_WIDTH  11             signed coefficient width
//  AMP_WIDTH   DATA_WIDTH+1   width of the DC difference and amplitude field
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst        in   1           asynchronous, active-high reset
//  dc_clr     in   1           sync pulse: DC predictor <= 0 (frame/component start)
//  in_valid   in   1           coefficient beat valid
//  in_ready   out  1           beat accepted when in_valid && in_ready
//  in_data    in   DATA_WIDTH  signed coefficient, zigzag index = internal beat count
//  out_valid  out  1           symbol valid; held stable until out_ready
//  out_ready  in   1           downstream accepts symbol
//  out_run    out  4           zero run (0..15), 15 for ZRL, 0 for EOB/DC
//  out_size   out  4           magnitude category (0..AMP_WIDTH)
//  out_amp    out  AMP_WIDTH   amplitude bits, LSB-aligned, upper bits zero
//  out_dc     out  1           symbol is the DC difference
//  out_eob    out  1           symbol is EOB (run=0,size=0)
//  out_last   out  1           last symbol of the current block
// BEHAVIOUR
//  Reset:
//   - All out_* = 0; in_ready = 1; beat index idx = 0; run = 0; predictor = 0; state = RUN.
//   - Reset mid-block discards the partial block; the next accepted beat is idx 0.
//  Size/amplitude of value v:
//   - size = bit length of |v| (0 when v=0).
//   - amp = v if v>0, else (v-1) truncated to size bits (ones' complement).
//   - DC diff = in_data - pred, computed at AMP_WIDTH bits; pred <= in_data on every idx-0 accept.
//  Output register: single stage, so symbol latency is 1 cycle after the accepting edge.
//   - A symbol is retired on out_valid && out_ready.
//   - in_ready = (state==RUN) && (!out_valid || out_ready). Full throughput when out_ready=1.
//  Per accepted beat in state RUN:
//   - idx 0: emit DC symbol: out_dc=1, run=0, size/amp of diff.
//   - idx 1..62, v=0: run++; no symbol.
//   - idx 1..63, v!=0, run<16: emit (run,size,amp); run<=0. At idx 63 this symbol has out_last=1.
//   - v!=0, run>=16: hold v; emit ZRL (15,0,0); run-=16; go to ZRL.
//   - idx 63, v=0: emit EOB with out_last=1; run<=0. Pending zero runs are never sent as ZRL.
//   - idx increments mod 64 on every accept; 63 wraps to 0.
//  State ZRL (in_ready=0), on each retire:
//   - if run>=16: emit next ZRL; run-=16.
//   - else: emit held symbol (run,size,amp), with out_last if it was idx 63; run<=0; go to RUN.
//   - At most 3 ZRLs per nonzero coefficient.
//  dc_clr:
//   - Takes effect that edge.
//   - If coincident with an idx-0 accept, diff uses pred=0; pred is then loaded with in_data.
//   - Does not affect idx, run or an in-flight symbol.
//  Flags: out_dc, out_eob, out_last are mutually consistent. DC is never last; EOB is always last.
//  Outputs must not change while out_valid && !out_ready.
// TESTING
//  1. Reset, block DC=40 then 63 zeros, out_ready=1 -> DC(0,6,40) then EOB last; 2 symbols; in_ready never drops.
//  2. Second block with DC=37 -> DC diff -3: size 2, amp 2'b00. dc_clr before a third block with DC=5 -> size 3, amp 5.
//  3. AC: idx1=-1, idx2=0, idx3=3, rest 0 -> (0,1,0), (1,2,3), EOB.
//  4. idx1..40 zero, idx41=7, rest 0 -> ZRL, ZRL, (8,3,7), EOB. in_ready low for 2 cycles.
//  5. idx63=-2 only nonzero (run 62) -> 3 ZRL, (14,2,1) with out_last=1, no EOB.
//  6. Random out_ready stalls, rst asserted mid-block -> outputs stable during stalls; post-reset block decodes from idx 0 with pred 0.

Source files
------------

// File: rtl/zigzag_rle_encoder.sv
// Zigzag-ordered coefficient to JPEG (run, size, amplitude) symbol encoder.
// DC is coded against a running predictor; AC is run-length coded with ZRL/EOB.
module zigzag_rle_encoder #(
  parameter int DATA_WIDTH = 11,
  parameter int AMP_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dc_clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_run,
  output logic [3:0]                   out_size,
  output logic [AMP_WIDTH-1:0]         out_amp,
  output logic                         out_dc,
  output logic                         out_eob,
  output logic                         out_last
);

  localparam int XW = AMP_WIDTH - DATA_WIDTH;

  typedef enum logic {S_RUN, S_ZRL} state_t;

  function automatic logic [3:0] f_size(
    input logic signed [AMP_WIDTH-1:0] v
  );
    logic [AMP_WIDTH-1:0] mag;
    f_size = '0;
    mag = v[AMP_WIDTH-1] ? (~v + 1'b1) : v;
    for (int i = 0; i < AMP_WIDTH; i++)
      if (mag[i]) f_size = 4'(i + 1);
  endfunction

  // negative values use ones' complement in the low size bits
  function automatic logic [AMP_WIDTH-1:0] f_amp(
    input logic signed [AMP_WIDTH-1:0] v,
    input logic [3:0]                  sz
  );
    logic [AMP_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < AMP_WIDTH; i++)
      if (i < int'(sz)) m[i] = 1'b1;
    f_amp = v[AMP_WIDTH-1] ? ((v - 1'b1) & m) : v;
  endfunction

  state_t                state, state_nxt;
  logic [5:0]            idx, run, run_nxt;
  logic [DATA_WIDTH-1:0] pred;
  logic [3:0]            hold_size;
  logic [AMP_WIDTH-1:0]  hold_amp;
  logic                  hold_last, hold_ld;

  logic                        accept, retire;
  logic signed [AMP_WIDTH-1:0] in_ext, pred_ext, diff, val;
  logic [3:0]                  val_size;
  logic [AMP_WIDTH-1:0]        val_amp;
  logic                        is_dc, is_zero, is_eob, is_zrl, is_ac;
  logic                        run_big;

  logic                 ld, s_dc, s_eob, s_last;
  logic [3:0]           s_run, s_size;
  logic [AMP_WIDTH-1:0] s_amp;

  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  assign in_ext   = {{XW{in_data[DATA_WIDTH-1]}}, in_data};
  assign pred_ext = dc_clr ? '0 : {{XW{pred[DATA_WIDTH-1]}}, pred};
  assign diff     = in_ext - pred_ext;
  assign val      = (idx == 6'd0) ? diff : in_ext;
  assign val_size = f_size(val);
  assign val_amp  = f_amp(val, val_size);
  assign run_big  = |run[5:4];

  assign is_dc   = (idx == 6'd0);
  assign is_zero = !is_dc && (val == '0) && !(&idx);
  assign is_eob  = !is_dc && (val == '0) && (&idx);
  assign is_zrl  = !is_dc && (val != '0) && run_big;
  assign is_ac   = !is_dc && (val != '0) && !run_big;

  always_comb begin
    ld        = 1'b0;
    s_run     = '0;
    s_size    = '0;
    s_amp     = '0;
    s_dc      = 1'b0;
    s_eob     = 1'b0;
    s_last    = 1'b0;
    state_nxt = state;
    run_nxt   = run;
    hold_ld   = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_dc: begin
          ld     = 1'b1;
          s_dc   = 1'b1;
          s_size = val_size;
          s_amp  = val_amp;
        end
        is_zero: run_nxt = run + 6'd1;
        is_eob: begin
          ld      = 1'b1;
          s_eob   = 1'b1;
          s_last  = 1'b1;
          run_nxt = '0;
        end
        is_zrl: begin
          ld        = 1'b1;
          s_run     = 4'd15;
          hold_ld   = 1'b1;
          run_nxt   = run - 6'd16;
          state_nxt = S_ZRL;
        end
        is_ac: begin
          ld      = 1'b1;
          s_run   = run[3:0];
          s_size  = val_size;
          s_amp   = val_amp;
          s_last  = &idx;
          run_nxt = '0;
        end
      endcase
    end else if (state == S_ZRL && retire) begin
      ld = 1'b1;
      if (run_big) begin
        s_run   = 4'd15;
        run_nxt = run - 6'd16;
      end else begin
        s_run     = run[3:0];
        s_size    = hold_size;
        s_amp     = hold_amp;
        s_last    = hold_last;
        run_nxt   = '0;
        state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      idx       <= '0;
      run       <= '0;
      pred      <= '0;
      hold_size <= '0;
      hold_amp  <= '0;
      hold_last <= 1'b0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_size  <= '0;
      out_amp   <= '0;
      out_dc    <= 1'b0;
      out_eob   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
      if (accept) idx <= idx + 6'd1;
      if (accept && is_dc) pred <= in_data;
      else if (dc_clr)     pred <= '0;
      if (hold_ld) begin
        hold_size <= val_size;
        hold_amp  <= val_amp;
        hold_last <= &idx;
      end
      if (ld) begin
        out_valid <= 1'b1;
        out_run   <= s_run;
        out_size  <= s_size;
        out_amp   <= s_amp;
        out_dc    <= s_dc;
        out_eob   <= s_eob;
        out_last  <= s_last;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Scoreboard bench for zigzag_rle_encoder: a software JPEG symbol model
// fills a queue per block; retired DUT symbols are popped and compared.
module tb_zigzag_rle_encoder;

  localparam int DW = 11;
  localparam int AW = DW + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 dc_clr = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [3:0]           out_run, out_size;
  logic [AW-1:0]        out_amp;
  logic                 out_dc, out_eob, out_last;

  int total = 0;
  int bad = 0;
  int low_cnt = 0;
  int mpred = 0;

  logic [22:0] q[$];
  logic        stalled_prev = 1'b0;
  logic [23:0] held_sym = '0;
  logic [22:0] cur_sym;

  assign cur_sym = {out_run, out_size, out_amp, out_dc, out_eob, out_last};

  zigzag_rle_encoder #(.DATA_WIDTH(DW), .AMP_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .dc_clr(dc_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_run(out_run), .out_size(out_size), .out_amp(out_amp),
    .out_dc(out_dc), .out_eob(out_eob), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int msize(input int v);
    int a, s;
    a = (v < 0) ? -v : v;
    s = 0;
    while (a > 0) begin
      s++;
      a = a >> 1;
    end
    return s;
  endfunction

  function automatic int mamp(input int v, input int s);
    if (v > 0) return v;
    return (v - 1) & ((1 << s) - 1);
  endfunction

  function automatic logic [22:0] sym(input int r, input int s, input int a,
                                      input bit dc, input bit eob,
                                      input bit last);
    return {4'(r), 4'(s), 12'(a), dc, eob, last};
  endfunction

  task automatic model(input int blk[64], input bit clr);
    int d, run, s;
    if (clr) mpred = 0;
    d = blk[0] - mpred;
    s = msize(d);
    q.push_back(sym(0, s, mamp(d, s), 1'b1, 1'b0, 1'b0));
    mpred = blk[0];
    run = 0;
    for (int i = 1; i < 64; i++) begin
      if (blk[i] == 0) begin
        if (i == 63) q.push_back(sym(0, 0, 0, 1'b0, 1'b1, 1'b1));
        else run++;
      end else begin
        while (run >= 16) begin
          q.push_back(sym(15, 0, 0, 1'b0, 1'b0, 1'b0));
          run -= 16;
        end
        s = msize(blk[i]);
        q.push_back(sym(run, s, mamp(blk[i], s), 1'b0, 1'b0, i == 63));
        run = 0;
      end
    end
  endtask

  // one cycle: drive at negedge, observe 1 time unit later
  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic clr, input int pct, output logic acc);
    logic [22:0] e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    dc_clr    = clr;
    out_ready = ($urandom_range(99) < pct);
    #1;
    if (stalled_prev)
      chk("stall_hold", 32'({out_valid, cur_sym}), 32'(held_sym));
    if (out_valid && out_ready) begin
      e = 'x;
      if (q.size() > 0) e = q.pop_front();
      chk("symbol", 32'(cur_sym), 32'(e));
    end
    stalled_prev = out_valid && !out_ready;
    held_sym = {out_valid, cur_sym};
    if (v && !in_ready) low_cnt++;
    acc = v && in_ready;
  endtask

  task automatic send_block(input int blk[64], input bit clr,
                            input int pct, input int n);
    int i, g;
    logic acc;
    model(blk, clr);
    low_cnt = 0;
    i = 0;
    g = 0;
    while (i < n && g < 3000) begin
      step(1'b1, blk[i][DW-1:0], clr && (i == 0), pct, acc);
      if (acc) i++;
      g++;
    end
    chk("beats_accepted", 32'(i), 32'(n));
    if (n == 64) begin
      g = 0;
      while ((q.size() > 0 || out_valid) && g < 500) begin
        step(1'b0, '0, 1'b0, pct, acc);
        g++;
      end
      chk("queue_drained", 32'(q.size()), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    dc_clr = 1'b0;
    q.delete();
    mpred = 0;
    stalled_prev = 1'b0;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fields", 32'(cur_sym), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int b[64];
    logic acc;

    do_reset(3);

    b = '{default: 0};
    b[0] = 40;
    send_block(b, 1'b0, 100, 64);
    chk("t1_in_ready_low", 32'(low_cnt), 32'd0);

    b[0] = 37;
    send_block(b, 1'b0, 100, 64);
    step(1'b0, '0, 1'b1, 100, acc);
    mpred = 0;
    b[0] = 5;
    send_block(b, 1'b0, 100, 64);

    b = '{default: 0};
    b[0] = 5;
    b[1] = -1;
    b[3] = 3;
    send_block(b, 1'b0, 100, 64);

    b = '{default: 0};
    b[0] = 9;
    b[41] = 7;
    send_block(b, 1'b0, 100, 64);
    chk("t4_in_ready_low", 32'(low_cnt), 32'd2);

    b = '{default: 0};
    b[0] = 9;
    b[63] = -2;
    send_block(b, 1'b0, 100, 64);

    b = '{default: 0};
    b[0] = 1023;
    send_block(b, 1'b0, 100, 64);
    b[0] = -1024;
    b[1] = 1023;
    b[2] = -1024;
    b[63] = 1;
    send_block(b, 1'b0, 100, 64);

    b = '{default: 0};
    b[0] = -300;
    b[17] = -5;
    b[50] = 200;
    send_block(b, 1'b1, 100, 64);

    for (int k = 0; k < 5; k++) begin
      b = '{default: 0};
      b[0] = int'($urandom_range(2047)) - 1024;
      for (int i = 1; i < 64; i++)
        if ($urandom_range(k * 6 + 2) == 0)
          b[i] = int'($urandom_range(2047)) - 1024;
      send_block(b, (k == 3), 60, 64);
    end

    b = '{default: 0};
    b[0] = 100;
    b[4] = 3;
    b[25] = -9;
    send_block(b, 1'b0, 50, 30);
    do_reset(2);

    b = '{default: 0};
    b[0] = 12;
    b[5] = -7;
    b[60] = 33;
    send_block(b, 1'b0, 70, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
